instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the decoder.
- Owns the architectural fetch PC and issues word-aligned requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Buffers returned instructions, with their PCs, in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts a branch/jump redirect from execute, which flushes all in-flight and buffered work.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; must be a power of two, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request present.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response data valid; exactly one per accepted request, in order, ≥ 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle pulse: change fetch PC.
- redirect_pc  in  32  new PC; bits [1:0] are ignored (treated as 0).
- instr_valid  out  1  FIFO head valid toward decode.
- instr_ready  in  1  decode consumes the head this cycle.
- instr_out  out  32  head instruction.
- instr_pc  out  32  PC of the head instruction.

Behaviour:
- Reset, asynchronous: fetch_pc=RESET_PC, state=REQ, FIFO empty, imem_req_valid=0 while rst is high, instr_valid=0, instr_out=0, instr_pc=0.
- One outstanding request maximum.
- imem_req_valid = (state==REQ) && (fifo_count < FIFO_DEPTH), using registered count only.
- imem_req_addr = fetch_pc.
- Request handshake: imem_req_valid && imem_req_ready. On handshake, fetch_pc <= fetch_pc+4, wrapping 32'hFFFF_FFFC -> 0, and req_pc <= fetch_pc.
- A request, once raised, holds its address until accepted. The only exception is a redirect, which replaces the address the next cycle.
- States:
  - REQ: no request outstanding.
  - WAIT: request outstanding, response to be kept.
  - DROP: request outstanding, response to be discarded.
- Transitions:
  - REQ, handshake, no redirect -> WAIT.
  - REQ, handshake with redirect -> DROP. The accepted request is stale.
  - REQ, redirect, no handshake -> REQ.
  - WAIT, rsp, no redirect -> REQ; push {imem_rsp_data, req_pc}.
  - WAIT, redirect, no rsp -> DROP.
  - WAIT, redirect with rsp -> REQ; response discarded.
  - DROP, rsp -> REQ; response discarded.
  - DROP, redirect -> DROP; fetch_pc updated.
- Redirect in cycle N:
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO cleared; any push or pop that cycle is ignored.
  - instr_valid=0 at N+1.
  - Earliest request with the new address at N+1.
  - Redirect has priority over the +4 increment.
- FIFO latency: a push in cycle M makes instr_valid high at M+1 when the FIFO was empty. There is no combinational bypass from imem_rsp_data to instr_out.
- FIFO occupancy:
  - Push and pop in the same cycle leave the count unchanged.
  - Pop when empty is ignored.
  - Push when full cannot occur: space is reserved at request issue. A bench assertion checks this.
- instr_out/instr_pc hold their value while instr_valid && !instr_ready.
- Throughput with 1-cycle memory: one instruction per 2 cycles (accepted limitation).
- rst asserted mid-transaction: the outstanding request is abandoned. Memory is reset by the same rst.

Decomposition:
- Package riscv_fetch_pkg holds:
  - fetch_state_t enum {REQ, WAIT, DROP}.
  - DEFAULT_RESET_PC.
  - INSTR_WIDTH=32.
  - PC_STEP=4.
- Sub-module fetch_fifo holds the instruction FIFO: parameterised depth and width (64 bits: instr+pc), synchronous flush input, same clk/rst.
- The top level holds the PC/FSM logic.

Test Plan:
- Reset release with 1-cycle memory, decode always ready -> requests at 0x0,0x4,0x8; instr_pc sequence 0x0,0x4,0x8, each instr_out equal to the memory word.
- instr_ready=0 for 10 cycles -> exactly 2 requests issued, then imem_req_valid=0; on release, PCs 0x0,0x4,0x8 delivered in order, none lost or duplicated.
- imem_req_ready low for 3 cycles at addr 0x8 -> address held stable at 0x8 until accepted.
- Redirect to 0x103 while WAIT on 0x4 with 3-cycle memory -> the 0x4 response is dropped; next request addr 0x100; first instr_pc=0x100.
- Redirect coincident with the request handshake and with an rsp in the same cycle -> both stale words discarded, FIFO empty next cycle, new PC fetched.
- RESET_PC=32'hFFFF_FFF8 -> request addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; rst pulsed mid-WAIT -> outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch top level and its instruction buffer.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two instruction buffer between fetch and decode.
// Output reads as zero when empty; flush wins over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: valid_o masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one request at a time,
// buffers returned words with their PCs for decode.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * INSTR_WIDTH;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] fifo_cnt;
  logic [EW-1:0] fifo_head;
  logic          hs, push;
  logic          unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // Space for the response is reserved when the request goes out.
  assign imem_req_valid = !rst && (state_q == REQ)
                        && (fifo_cnt < CW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign hs             = imem_req_valid && imem_req_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    if (hs) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      req_pc_d   = fetch_pc_q;
    end
    if (redirect_valid) fetch_pc_d = {redirect_pc[31:2], 2'b00};
    unique case (state_q)
      REQ: begin
        if (hs) state_d = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  ({imem_rsp_data, req_pc_q}),
    .pop_i   (instr_ready),
    .valid_o (instr_valid),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign instr_out = fifo_head[EW-1:INSTR_WIDTH];
  assign instr_pc  = fifo_head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based model checked every cycle,
// plus directed scenarios with literal expected PCs.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 0;
  logic        rst = 0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;

  logic        rst2 = 0;
  logic        req2_valid;
  logic        req2_ready = 1'b1;
  logic [31:0] req2_addr;
  logic        rsp2_valid = 1'b0;
  logic [31:0] rsp2_data = '0;
  logic        redir2 = 1'b0;
  logic [31:0] redir2_pc = '0;
  logic        instr2_valid;
  logic        instr2_ready = 1'b1;
  logic [31:0] instr2_out, instr2_pc;

  int n_checks = 0;
  int n_err = 0;
  int mem_lat = 1;

  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];
  logic [31:0] acc2_log[$];
  logic [31:0] del2_log[$];

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .redirect_valid (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  instr_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFF8),
    .FIFO_DEPTH (DEPTH)
  ) u_dut2 (
    .clk            (clk),
    .rst            (rst2),
    .imem_req_valid (req2_valid),
    .imem_req_ready (req2_ready),
    .imem_req_addr  (req2_addr),
    .imem_rsp_valid (rsp2_valid),
    .imem_rsp_data  (rsp2_data),
    .redirect_valid (redir2),
    .redirect_pc    (redir2_pc),
    .instr_valid    (instr2_valid),
    .instr_ready    (instr2_ready),
    .instr_out      (instr2_out),
    .instr_pc       (instr2_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act,
                               input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  function automatic void timeout(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Memory for the main DUT: one response mem_lat cycles after acceptance.
  initial begin : mem_proc
    logic acc, rst_s, pend;
    logic [31:0] a_addr, p_addr;
    int cnt;
    rsp_valid = 0;
    rsp_data = '0;
    pend = 0;
    cnt = 0;
    p_addr = '0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      acc = req_valid && req_ready;
      a_addr = req_addr;
      @(posedge clk);
      #1;
      rsp_valid = 0;
      if (rst_s) begin
        pend = 0;
      end else begin
        if (acc) begin
          pend = 1;
          p_addr = a_addr;
          cnt = mem_lat;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            rsp_valid = 1;
            rsp_data = mem_word(p_addr);
            pend = 0;
          end
        end
      end
    end
  end

  // Memory and logging for the second DUT (always ready, 1-cycle).
  initial begin : mem2_proc
    logic a2;
    logic [31:0] ad2;
    forever begin
      @(negedge clk);
      a2 = req2_valid && req2_ready;
      ad2 = req2_addr;
      if (a2 && acc2_log.size() < 8) acc2_log.push_back(req2_addr);
      if (instr2_valid && del2_log.size() < 8) del2_log.push_back(instr2_pc);
      @(posedge clk);
      #1;
      rsp2_valid = a2;
      rsp2_data = mem_word(ad2);
    end
  end

  // Reference model: fetch PC, one-outstanding flag, stale flag, queue.
  logic [31:0] m_pc, m_reqpc;
  logic        m_out, m_stale;
  logic [63:0] m_q[$];

  initial begin : model_proc
    logic m_hs, m_pop, m_rsp;
    m_pc = '0;
    m_reqpc = '0;
    m_out = 0;
    m_stale = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        m_pc = 32'h0;
        m_q.delete();
        m_out = 0;
        m_stale = 0;
      end else begin
        m_hs = !m_out && (m_q.size() < DEPTH);
        chk1("req_valid", req_valid, m_hs);
        if (m_hs) chk("req_addr", req_addr, m_pc);
        chk1("instr_valid", instr_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          chk("instr_out", instr_out, m_q[0][63:32]);
          chk("instr_pc", instr_pc, m_q[0][31:0]);
        end
        m_hs = m_hs && req_ready;
        m_pop = (m_q.size() > 0) && instr_ready;
        m_rsp = m_out && rsp_valid;
        if (m_hs) acc_log.push_back(m_pc);
        if (m_pop && !redirect) del_log.push_back(m_q[0][31:0]);
        if (redirect) begin
          m_q.delete();
          m_pc = {redirect_pc[31:2], 2'b00};
          if (m_hs) begin
            m_out = 1;
            m_stale = 1;
          end else if (m_rsp) begin
            m_out = 0;
          end else if (m_out) begin
            m_stale = 1;
          end
        end else begin
          if (m_pop) void'(m_q.pop_front());
          if (m_rsp) begin
            if (!m_stale) begin
              chk1("space_reserved", m_q.size() < DEPTH, 1'b1);
              m_q.push_back({mem_word(m_reqpc), m_reqpc});
            end
            m_out = 0;
            m_stale = 0;
          end
          if (m_hs) begin
            m_reqpc = m_pc;
            m_pc = m_pc + 32'd4;
            m_out = 1;
            m_stale = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1;
    cyc(2);
    rst = 0;
    acc_log.delete();
    del_log.delete();
  endtask

  initial begin : stim
    int k, n0, c8;
    req_ready = 1;
    instr_ready = 1;
    redirect = 0;
    redirect_pc = '0;
    mem_lat = 1;
    #1;
    rst = 1;
    rst2 = 1;
    #3;
    chk1("t0_reset_req_valid", req_valid, 1'b0);
    chk1("t0_reset_instr_valid", instr_valid, 1'b0);
    chk("t0_reset_instr_out", instr_out, 32'h0);
    chk("t0_reset_instr_pc", instr_pc, 32'h0);
    cyc(2);
    rst = 0;
    rst2 = 0;
    acc_log.delete();
    del_log.delete();

    // Streaming with 1-cycle memory
    cyc(12);
    chk("t0_req0", at(acc_log, 0), 32'h0);
    chk("t0_req1", at(acc_log, 1), 32'h4);
    chk("t0_req2", at(acc_log, 2), 32'h8);
    chk("t0_pc0", at(del_log, 0), 32'h0);
    chk("t0_pc1", at(del_log, 1), 32'h4);
    chk("t0_pc2", at(del_log, 2), 32'h8);

    // Decode stalled: buffer fills, requests stop
    rst = 1;
    instr_ready = 0;
    cyc(2);
    rst = 0;
    acc_log.delete();
    del_log.delete();
    cyc(10);
    chk("t1_req_count", 32'(acc_log.size()), 32'd2);
    chk1("t1_req_stopped", req_valid, 1'b0);
    instr_ready = 1;
    cyc(14);
    chk("t1_pc0", at(del_log, 0), 32'h0);
    chk("t1_pc1", at(del_log, 1), 32'h4);
    chk("t1_pc2", at(del_log, 2), 32'h8);
    chk("t1_pc3", at(del_log, 3), 32'hC);

    // Memory back-pressure at 0x8
    do_reset();
    k = 0;
    while (!(req_valid && req_addr == 32'h8) && k < 30) begin
      cyc(1);
      k++;
    end
    if (k >= 30) timeout("t2_wait_addr8");
    req_ready = 0;
    repeat (3) begin
      chk1("t2_hold_valid", req_valid, 1'b1);
      chk("t2_hold_addr", req_addr, 32'h8);
      cyc(1);
    end
    req_ready = 1;
    cyc(1);
    chk("t2_accepted", acc_log[$], 32'h8);
    c8 = 0;
    foreach (acc_log[i]) if (acc_log[i] == 32'h8) c8++;
    chk("t2_once", 32'(c8), 32'd1);

    // Redirect while waiting on 0x4 with 3-cycle memory
    mem_lat = 3;
    do_reset();
    k = 0;
    while (acc_log.size() < 2 && k < 30) begin
      cyc(1);
      k++;
    end
    if (k >= 30) timeout("t3_wait_req4");
    chk("t3_waiting_on", at(acc_log, 1), 32'h4);
    n0 = acc_log.size();
    del_log.delete();
    redirect = 1;
    redirect_pc = 32'h103;
    cyc(1);
    redirect = 0;
    chk1("t3_flushed", instr_valid, 1'b0);
    cyc(16);
    chk("t3_new_req", at(acc_log, n0), 32'h100);
    chk("t3_pc0", at(del_log, 0), 32'h100);
    chk("t3_pc1", at(del_log, 1), 32'h104);

    // Redirect on the request handshake
    mem_lat = 1;
    do_reset();
    k = 0;
    while (!(req_valid && req_addr == 32'h4) && k < 30) begin
      cyc(1);
      k++;
    end
    if (k >= 30) timeout("t4a_wait_addr4");
    n0 = acc_log.size();
    del_log.delete();
    redirect = 1;
    redirect_pc = 32'h200;
    cyc(1);
    redirect = 0;
    chk1("t4a_flushed", instr_valid, 1'b0);
    chk1("t4a_no_req_while_drop", req_valid, 1'b0);
    cyc(10);
    chk("t4a_stale_req", at(acc_log, n0), 32'h4);
    chk("t4a_new_req", at(acc_log, n0 + 1), 32'h200);
    chk("t4a_pc0", at(del_log, 0), 32'h200);

    // Redirect coincident with a response
    mem_lat = 2;
    do_reset();
    k = 0;
    while (!(rsp_valid && acc_log.size() >= 2) && k < 30) begin
      cyc(1);
      k++;
    end
    if (k >= 30) timeout("t4b_wait_rsp");
    del_log.delete();
    redirect = 1;
    redirect_pc = 32'h302;
    cyc(1);
    redirect = 0;
    chk1("t4b_flushed", instr_valid, 1'b0);
    chk1("t4b_req_valid", req_valid, 1'b1);
    chk("t4b_req_addr", req_addr, 32'h300);
    cyc(12);
    chk("t4b_pc0", at(del_log, 0), 32'h300);

    // Reset pulsed mid-WAIT with a buffered instruction
    mem_lat = 3;
    instr_ready = 0;
    do_reset();
    k = 0;
    while (acc_log.size() < 2 && k < 30) begin
      cyc(1);
      k++;
    end
    if (k >= 30) timeout("t5_wait_req4");
    chk1("t5_pre_valid", instr_valid, 1'b1);
    rst = 1;
    #1;
    chk1("t5_rst_req_valid", req_valid, 1'b0);
    chk1("t5_rst_instr_valid", instr_valid, 1'b0);
    chk("t5_rst_instr_out", instr_out, 32'h0);
    chk("t5_rst_instr_pc", instr_pc, 32'h0);
    cyc(2);
    rst = 0;
    instr_ready = 1;
    acc_log.delete();
    del_log.delete();
    cyc(12);
    chk("t5_restart_req", at(acc_log, 0), 32'h0);
    chk("t5_restart_pc", at(del_log, 0), 32'h0);

    // Second instance: wrap from the top of the address space
    chk("t6_req0", at(acc2_log, 0), 32'hFFFF_FFF8);
    chk("t6_req1", at(acc2_log, 1), 32'hFFFF_FFFC);
    chk("t6_req2", at(acc2_log, 2), 32'h0000_0000);
    chk("t6_pc0", at(del2_log, 0), 32'hFFFF_FFF8);
    chk("t6_pc1", at(del2_log, 1), 32'hFFFF_FFFC);
    chk("t6_pc2", at(del2_log, 2), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
